// File: rtl/ro_pkg.sv
// Shared types and widths for the ring-oscillator measurement sequencer.
package ro_pkg;

   localparam int RO_CNT_W = 15;
   localparam int RO_TAP_W = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_WINDOW,
      S_SETTLE,
      S_SAMPLE,
      S_OUTPUT
   } ro_state_e;

endpackage

// File: rtl/ro_cycle_timer.sv
// Loadable down-counter shared by the ARM, WINDOW and SETTLE phases; done at zero.
module ro_cycle_timer #(
   parameter int TMR_W = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [TMR_W-1:0] load_val_i,
   output logic             done_o
);

   logic [TMR_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/ro_meas_sequencer.sv
// Opens timed oscillator-counter windows, samples the frozen count twice per window,
// averages 2^AVG_LOG2 windows per tap and hands each result out on valid/ready.
module ro_meas_sequencer
   import ro_pkg::*;
#(
   parameter int CNT_W         = RO_CNT_W,
   parameter int WINDOW_CYCLES = 1024,
   parameter int SETTLE_CYCLES = 8,
   parameter int AVG_LOG2      = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic                sweep_i,
   input  logic [RO_TAP_W-1:0] tap_sel_i,
   input  logic [CNT_W-1:0]    cnt_in_i,
   output logic                osc_en_o,
   output logic [RO_TAP_W-1:0] tap_o,
   output logic                busy_o,
   output logic                res_valid_o,
   input  logic                res_ready_i,
   output logic [CNT_W-1:0]    res_data_o,
   output logic [RO_TAP_W-1:0] res_tap_o,
   output logic                res_unstbl_o
);

   localparam int TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int ACC_W   = CNT_W + AVG_LOG2;
   localparam int NWIN_W  = AVG_LOG2 + 1;
   localparam logic [NWIN_W-1:0] WIN_LAST   = NWIN_W'((1 << AVG_LOG2) - 1);
   localparam logic [TMR_W-1:0]  LOAD_WIN   = TMR_W'(WINDOW_CYCLES - 1);
   localparam logic [TMR_W-1:0]  LOAD_SETTLE = TMR_W'(SETTLE_CYCLES - 1);

   ro_state_e             state_q, state_d;
   logic                  sweep_q, sweep_d;
   logic [RO_TAP_W-1:0]   tap_q, tap_d;
   logic                  busy_q, busy_d;
   logic                  osc_en_q, osc_en_d;
   logic                  phase_q, phase_d;
   logic [NWIN_W-1:0]     win_q, win_d;
   logic [CNT_W-1:0]      s0_q, s0_d;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic                  unstbl_q, unstbl_d;
   logic                  res_valid_q, res_valid_d;
   logic [CNT_W-1:0]      res_data_q, res_data_d;
   logic [RO_TAP_W-1:0]   res_tap_q, res_tap_d;
   logic                  res_unstbl_q, res_unstbl_d;

   logic                  tmr_load;
   logic [TMR_W-1:0]      tmr_val;
   logic                  tmr_done;
   logic [ACC_W-1:0]      acc_sum;
   logic                  unstbl_sum;

   ro_cycle_timer #(.TMR_W(TMR_W)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .done_o     (tmr_done)
   );

   // Second sample is the one accumulated; the first only guards against a moving count.
   assign acc_sum    = acc_q + ACC_W'(cnt_in_i);
   assign unstbl_sum = unstbl_q | (s0_q != cnt_in_i);

   always_comb begin
      state_d      = state_q;
      sweep_d      = sweep_q;
      tap_d        = tap_q;
      busy_d       = busy_q;
      phase_d      = phase_q;
      win_d        = win_q;
      s0_d         = s0_q;
      acc_d        = acc_q;
      unstbl_d     = unstbl_q;
      res_valid_d  = res_valid_q;
      res_data_d   = res_data_q;
      res_tap_d    = res_tap_q;
      res_unstbl_d = res_unstbl_q;
      tmr_load     = 1'b0;
      tmr_val      = LOAD_SETTLE;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               sweep_d  = sweep_i;
               tap_d    = sweep_i ? '0 : tap_sel_i;
               busy_d   = 1'b1;
               acc_d    = '0;
               unstbl_d = 1'b0;
               win_d    = '0;
               phase_d  = 1'b0;
               tmr_load = 1'b1;
               state_d  = S_ARM;
            end
         end
         S_ARM: begin
            if (tmr_done) begin
               tmr_load = 1'b1;
               tmr_val  = LOAD_WIN;
               state_d  = S_WINDOW;
            end
         end
         S_WINDOW: begin
            if (tmr_done) begin
               tmr_load = 1'b1;
               state_d  = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (tmr_done) begin
               phase_d = 1'b0;
               state_d = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            if (!phase_q) begin
               s0_d    = cnt_in_i;
               phase_d = 1'b1;
            end else begin
               phase_d  = 1'b0;
               acc_d    = acc_sum;
               unstbl_d = unstbl_sum;
               if (win_q == WIN_LAST) begin
                  res_valid_d  = 1'b1;
                  res_data_d   = CNT_W'(acc_sum >> AVG_LOG2);
                  res_tap_d    = tap_q;
                  res_unstbl_d = unstbl_sum;
                  state_d      = S_OUTPUT;
               end else begin
                  win_d    = win_q + 1'b1;
                  tmr_load = 1'b1;
                  state_d  = S_ARM;
               end
            end
         end
         S_OUTPUT: begin
            if (res_ready_i) begin
               res_valid_d = 1'b0;
               acc_d       = '0;
               unstbl_d    = 1'b0;
               win_d       = '0;
               if (sweep_q && (tap_q != '1)) begin
                  tap_d    = tap_q + 1'b1;
                  tmr_load = 1'b1;
                  state_d  = S_ARM;
               end else begin
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Registered so the enable is high in exactly the WINDOW cycles.
      osc_en_d = (state_d == S_WINDOW);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         sweep_q      <= 1'b0;
         tap_q        <= '0;
         busy_q       <= 1'b0;
         osc_en_q     <= 1'b0;
         phase_q      <= 1'b0;
         win_q        <= '0;
         s0_q         <= '0;
         acc_q        <= '0;
         unstbl_q     <= 1'b0;
         res_valid_q  <= 1'b0;
         res_data_q   <= '0;
         res_tap_q    <= '0;
         res_unstbl_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sweep_q      <= sweep_d;
         tap_q        <= tap_d;
         busy_q       <= busy_d;
         osc_en_q     <= osc_en_d;
         phase_q      <= phase_d;
         win_q        <= win_d;
         s0_q         <= s0_d;
         acc_q        <= acc_d;
         unstbl_q     <= unstbl_d;
         res_valid_q  <= res_valid_d;
         res_data_q   <= res_data_d;
         res_tap_q    <= res_tap_d;
         res_unstbl_q <= res_unstbl_d;
      end
   end

   assign osc_en_o     = osc_en_q;
   assign tap_o        = tap_q;
   assign busy_o       = busy_q;
   assign res_valid_o  = res_valid_q;
   assign res_data_o   = res_data_q;
   assign res_tap_o    = res_tap_q;
   assign res_unstbl_o = res_unstbl_q;

endmodule

// File: tb/tb_ro_meas_sequencer.sv
// Bench for ro_meas_sequencer: models the counter stage and predicts each averaged result.
module tb_ro_meas_sequencer;

   localparam int CNT_W = 15;
   localparam int WIN   = 1024;
   localparam int SET   = 8;
   localparam int AVG   = 2;
   localparam int NAVG  = 1 << AVG;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start_i = 1'b0;
   logic             sweep_i = 1'b0;
   logic [2:0]       tap_sel_i = 3'd0;
   logic [CNT_W-1:0] cnt_in_i = '0;
   logic             res_ready_i = 1'b0;
   logic             osc_en_o;
   logic [2:0]       tap_o;
   logic             busy_o;
   logic             res_valid_o;
   logic [CNT_W-1:0] res_data_o;
   logic [2:0]       res_tap_o;
   logic             res_unstbl_o;

   ro_meas_sequencer #(
      .CNT_W(CNT_W), .WINDOW_CYCLES(WIN), .SETTLE_CYCLES(SET), .AVG_LOG2(AVG)
   ) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .sweep_i(sweep_i), .tap_sel_i(tap_sel_i),
      .cnt_in_i(cnt_in_i), .osc_en_o(osc_en_o), .tap_o(tap_o), .busy_o(busy_o),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
      .res_tap_o(res_tap_o), .res_unstbl_o(res_unstbl_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Counter stage: counts oscillator periods while enabled, clears on enable rise,
   // holds when enable is low. Optionally disturbs the second sample of one window.
   int  per_fixed    = 2;
   bit  per_from_tap = 1'b0;
   int  glitch_rise  = 0;
   int  rise_cnt     = 0;
   int  osc_ph       = 0;
   int  low_n        = 0;
   int  model_cnt    = 0;
   bit  en_prev      = 1'b0;

   always @(negedge clk) begin
      int per;
      per = per_from_tap ? (2 + int'(tap_o)) : per_fixed;
      if (osc_en_o) begin
         if (!en_prev) begin
            model_cnt = 0;
            osc_ph    = 0;
            rise_cnt++;
         end
         osc_ph++;
         if (osc_ph >= per) begin
            model_cnt++;
            osc_ph = 0;
         end
         low_n    = 0;
         cnt_in_i = CNT_W'(model_cnt);
      end else begin
         low_n++;
         if (glitch_rise != 0 && rise_cnt == glitch_rise && low_n == SET + 2)
            cnt_in_i = CNT_W'(model_cnt + 1);
         else
            cnt_in_i = CNT_W'(model_cnt);
      end
      en_prev = osc_en_o;
   end

   task automatic do_start(input bit sw, input logic [2:0] ts);
      @(negedge clk);
      sweep_i   = sw;
      tap_sel_i = ts;
      start_i   = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (res_valid_o !== 1'b1 && n < 6000) begin
         @(negedge clk);
         n++;
      end
      if (res_valid_o !== 1'b1) check_val({tag, "_timeout"}, 32'(res_valid_o), 1);
   endtask

   task automatic handshake();
      res_ready_i = 1'b1;
      @(negedge clk);
      res_ready_i = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_osc_en"}, 32'(osc_en_o), 0);
      check_val({tag, "_tap"}, 32'(tap_o), 0);
      check_val({tag, "_busy"}, 32'(busy_o), 0);
      check_val({tag, "_res_valid"}, 32'(res_valid_o), 0);
      check_val({tag, "_res_data"}, 32'(res_data_o), 0);
      check_val({tag, "_res_tap"}, 32'(res_tap_o), 0);
      check_val({tag, "_res_unstbl"}, 32'(res_unstbl_o), 0);
   endtask

   initial begin
      int n;
      int base;
      int extra;
      int exp_data;
      int g;
      int prev;
      logic [2:0] ts;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      // Single tap, period 2, with an ignored start mid-window
      per_from_tap = 1'b0;
      per_fixed    = 2;
      glitch_rise  = 0;
      base         = rise_cnt;
      do_start(1'b0, 3'd5);
      n = 1;
      while (!osc_en_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_val("arm_len", n, SET + 1);
      check_val("single_tap_out", 32'(tap_o), 5);
      check_val("single_busy", 32'(busy_o), 1);
      repeat (100) @(negedge clk);
      sweep_i   = 1'b1;
      tap_sel_i = 3'd2;
      start_i   = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      check_val("ignored_start_tap", 32'(tap_o), 5);
      wait_valid("single");
      check_val("single_data", 32'(res_data_o), 512);
      check_val("single_res_tap", 32'(res_tap_o), 5);
      check_val("single_unstbl", 32'(res_unstbl_o), 0);
      check_val("single_busy_before_hs", 32'(busy_o), 1);
      handshake();
      check_val("single_valid_after_hs", 32'(res_valid_o), 0);
      check_val("single_busy_after_hs", 32'(busy_o), 0);
      extra = 0;
      repeat (200) begin
         @(negedge clk);
         if (res_valid_o) extra++;
      end
      check_val("single_one_result", extra, 0);
      check_val("single_windows", rise_cnt - base, NAVG);

      // Sweep: period 2+tap, back-pressure on tap 3, disturbed sample in tap 1 window 2
      per_from_tap = 1'b1;
      base         = rise_cnt;
      glitch_rise  = base + NAVG + 2;
      do_start(1'b1, 3'($urandom));
      prev = 32'h7fff_ffff;
      for (int t = 0; t < 8; t++) begin
         wait_valid($sformatf("sweep%0d", t));
         g        = (t == 1) ? 1 : 0;
         exp_data = (NAVG * (WIN / (2 + t)) + g) / NAVG;
         check_val($sformatf("sweep%0d_data", t), 32'(res_data_o), exp_data);
         check_val($sformatf("sweep%0d_tap", t), 32'(res_tap_o), t);
         check_val($sformatf("sweep%0d_unstbl", t), 32'(res_unstbl_o), g);
         check_val($sformatf("sweep%0d_decr", t), 32'(int'(res_data_o) < prev), 1);
         prev = int'(res_data_o);
         if (t == 3) begin
            repeat (50) begin
               check_val("bp_valid", 32'(res_valid_o), 1);
               check_val("bp_data", 32'(res_data_o), exp_data);
               check_val("bp_tap", 32'(res_tap_o), 3);
               check_val("bp_osc_en", 32'(osc_en_o), 0);
               @(negedge clk);
            end
         end else begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
         end
         handshake();
         check_val($sformatf("sweep%0d_valid_drop", t), 32'(res_valid_o), 0);
         if (t < 7) begin
            check_val($sformatf("sweep%0d_next_tap", t), 32'(tap_o), t + 1);
            check_val($sformatf("sweep%0d_busy", t), 32'(busy_o), 1);
         end else begin
            check_val("sweep_done_busy", 32'(busy_o), 0);
         end
      end
      check_val("sweep_windows", rise_cnt - base, 8 * NAVG);

      // Reset in the middle of a window
      per_from_tap = 1'b0;
      per_fixed    = 3;
      glitch_rise  = 0;
      do_start(1'b0, 3'($urandom));
      n = 0;
      while (!osc_en_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_val("rst_window_open", 32'(osc_en_o), 1);
      repeat ($urandom_range(10, 500)) @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      check_val("midrst_busy_held", 32'(busy_o), 0);
      rst = 1'b0;

      // Fresh measurement after reset
      per_fixed = int'($urandom_range(2, 9));
      ts        = 3'($urandom);
      base      = rise_cnt;
      do_start(1'b0, ts);
      wait_valid("fresh");
      check_val("fresh_data", 32'(res_data_o), WIN / per_fixed);
      check_val("fresh_tap", 32'(res_tap_o), 32'(ts));
      check_val("fresh_unstbl", 32'(res_unstbl_o), 0);
      handshake();
      check_val("fresh_busy", 32'(busy_o), 0);
      check_val("fresh_windows", rise_cnt - base, NAVG);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
